gfx_cmd_issuer: RTL and testbench
=================================

# gfx_cmd_issuer

Host-side serializer that turns one parallel draw request (point or line) into the byte stream consumed by the CCU on its `cmd` input, one byte per `clk`. It is the initiator end of the CCU command protocol: it emits the opcode, the parameter bytes, the pad bytes the CCU spends on DPU setup, and a post-line gap. It sits between the host request logic and the CCU `cmd` port.

## Interface
- `PAD_BYTE`, 8'd0, byte driven whenever no frame byte is due; must not equal 8'd76 or 8'd80
- `SETUP_PAD`, 5, pad bytes between the colour byte and the start-X byte of a line frame
- `GAP_CYCLES`, 4, pad cycles after a line frame before the next opcode may be driven
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  host request present
- `req_ready`  out  1  issuer can accept a request this cycle
- `req_line`  in  1  1 = line, 0 = point
- `req_x0`, `req_y0`  in  8 each  point coordinate / line start
- `req_x1`, `req_y1`  in  8 each  line end (ignored for points)
- `req_colour`  in  8  colour byte
- `cmd`  out  8  registered command byte to the CCU
- `busy`  out  1  high while a frame or its gap is in progress
- `frame_done`  out  1  one-cycle pulse after the last non-pad byte of a frame

## Operation
- Handshake: a request is accepted on a rising edge with `req_valid && req_ready`. All request fields are captured on that edge. Inputs are don't-care otherwise.
- Point frame, 4 bytes: 8'd80 ('P'), X0, Y0, colour.
- Line frame, 8+SETUP_PAD bytes: 8'd76 ('L'), Xs, Ys, Xe, Ye, colour, then SETUP_PAD × PAD_BYTE, then Xs, Ys.
- Endpoint normalisation: if `req_x1 < req_x0` (unsigned), then Xs/Ys = x1/y1 and Xe/Ye = x0/y0. Otherwise they are x0/y0 and x1/y1. Equal X keeps the given order.
- FSM states:
  - IDLE: `cmd`=PAD_BYTE. Goes to SEND on accept.
  - SEND: byte index 0..N-1, one byte per cycle. After the last byte, a line goes to GAP. A point goes to IDLE, or to SEND if the queue is full.
  - GAP: GAP_CYCLES cycles of PAD_BYTE. Goes to IDLE, or to SEND if the queue holds a request. With GAP_CYCLES=0, GAP is skipped.
- `req_ready` = (state==IDLE) without queue; see Configuration.
- `busy` = state != IDLE.
- `frame_done` is asserted for exactly the cycle after the last frame byte is on `cmd`.
- Byte counter is 4 bits and never wraps within a frame; SETUP_PAD ≤ 7 is required.

## Timing
- Reset values: `cmd`=PAD_BYTE, `req_ready`=0 while `rst` is high and 1 on the first cycle after, `busy`=0, `frame_done`=0. Queue is empty, state is IDLE.
- Latency: the opcode appears on `cmd` in the cycle after the accepting edge. The frame bytes follow on consecutive cycles with no bubbles.
- Point-to-point: the next opcode may be driven in the cycle immediately after the colour byte (no gap).
- Line: the next opcode is no earlier than GAP_CYCLES+1 cycles after the final Ys byte.
- `rst` mid-frame: the frame is abandoned. On the next cycle `cmd`=PAD_BYTE and the queue is cleared. No `frame_done` is produced for the abandoned frame.
- `rst` has priority over a simultaneous accept; the request is dropped.

## Configuration
- `GFX_CMD_QUEUE_EN` defined: adds a one-entry request queue.
  - `req_ready` = queue empty, so a request can be accepted during SEND/GAP.
  - A queued request starts in the cycle after its predecessor's frame (point) or gap (line) ends.
  - A request accepted while IDLE with the queue empty bypasses the queue; latency is unchanged.
- Undefined: no queue; `req_ready` is high only in IDLE.

## Test plan
- Reset then point (5,7,colour 0x3C) → `cmd` = 80, 5, 7, 0x3C on cycles 1–4 after accept; `frame_done` pulse on cycle 5; `cmd`=0 afterwards.
- Line (x0=2,y0=1,x1=10,y1=4,c=0xFF), defaults → 76, 2, 1, 10, 4, 0xFF, 0×5, 2, 1; then 4 cycles of 0; `busy` falls after the gap.
- Line with x0=10,y0=4,x1=2,y1=1 → bytes identical to the previous case (swapped to 2,1,10,4).
- Reset asserted on the 3rd byte of a line frame → `cmd`=0 next cycle, `busy`=0, no `frame_done`. A new point request then issues normally.
- With GAP_CYCLES_... defaults and no queue: request held valid during a line frame → `req_ready`=0 until IDLE; accepted on the first IDLE cycle.
- With `GFX_CMD_QUEUE_EN`: point accepted mid-line → 'P' (80) driven in the cycle immediately after the 4th gap cycle; `req_ready` low while the queue is full.

Source files
------------

// File: rtl/gfx_cmd_issuer.sv
// -----------------------------------------------------------------------------
// gfx_cmd_issuer
//
// Host-side serializer for the CCU command protocol. One parallel draw request
// (point or line) becomes a byte stream on `cmd`, one byte per clock:
//   point : 'P'(80), X0, Y0, colour
//   line  : 'L'(76), Xs, Ys, Xe, Ye, colour, SETUP_PAD x PAD_BYTE, Xs, Ys
//           then GAP_CYCLES cycles of PAD_BYTE before the next opcode.
// Line endpoints are ordered so that Xs <= Xe (equal X keeps the given order).
//
// Optional feature macro: GFX_CMD_QUEUE_EN
//   defined   : one-entry request queue. req_ready = queue empty, so a request
//               can be taken while a frame or gap is running. It starts in the
//               cycle after the running frame (point) or gap (line) ends.
//   undefined : no queue, req_ready is high only while idle.
//
// Parameters:
//   PAD_BYTE   byte driven when no frame byte is due (must not be 76 or 80)
//   SETUP_PAD  pad bytes between colour and the trailing Xs (0..7)
//   GAP_CYCLES pad cycles after a line frame (0 skips the gap)
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   req_valid/ready   request handshake, fields captured on the accepting edge
//   req_line          1 = line, 0 = point
//   req_x0..req_y1    coordinates, req_colour colour byte
//   cmd               registered command byte to the CCU
//   busy              high while a frame or its gap is in progress
//   frame_done        one-cycle pulse in the cycle after the last frame byte
// -----------------------------------------------------------------------------
module gfx_cmd_issuer #(
    parameter logic [7:0] PAD_BYTE   = 8'd0,
    parameter int         SETUP_PAD  = 5,
    parameter int         GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_line,
    input  logic [7:0] req_x0,
    input  logic [7:0] req_y0,
    input  logic [7:0] req_x1,
    input  logic [7:0] req_y1,
    input  logic [7:0] req_colour,
    output logic [7:0] cmd,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] OP_POINT   = 8'd80;
    localparam logic [7:0] OP_LINE    = 8'd76;
    localparam logic [3:0] POINT_LAST = 4'd3;
    // Trailing Xs/Ys of a line sit right after the setup pad run.
    localparam logic [3:0] TAIL_X     = 4'(SETUP_PAD + 6);
    localparam logic [3:0] TAIL_Y     = 4'(SETUP_PAD + 7);
    localparam logic [3:0] LINE_LAST  = TAIL_Y;
    localparam logic       HAS_GAP    = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam int         GAP_LAST_I = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam logic [7:0] GAP_LAST   = 8'(GAP_LAST_I);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // A request after endpoint ordering; this is what a frame is built from.
    typedef struct packed {
        logic       line;
        logic [7:0] xs;
        logic [7:0] ys;
        logic [7:0] xe;
        logic [7:0] ye;
        logic [7:0] colour;
    } frame_t;

    // Orders line endpoints by X; points keep their coordinate untouched.
    function automatic frame_t normalise(input logic       line,
                                         input logic [7:0] x0,
                                         input logic [7:0] y0,
                                         input logic [7:0] x1,
                                         input logic [7:0] y1,
                                         input logic [7:0] colour);
        frame_t f;
        f.line   = line;
        f.colour = colour;
        if (line && (x1 < x0)) begin
            f.xs = x1;
            f.ys = y1;
            f.xe = x0;
            f.ye = y0;
        end else begin
            f.xs = x0;
            f.ys = y0;
            f.xe = x1;
            f.ye = y1;
        end
        return f;
    endfunction

    // Byte at position idx of the frame described by f.
    function automatic logic [7:0] frame_byte(input frame_t f, input logic [3:0] idx);
        logic [7:0] b;
        b = PAD_BYTE;
        if (!f.line) begin
            case (idx)
                4'd0:    b = OP_POINT;
                4'd1:    b = f.xs;
                4'd2:    b = f.ys;
                4'd3:    b = f.colour;
                default: b = PAD_BYTE;
            endcase
        end else begin
            case (idx)
                4'd0:    b = OP_LINE;
                4'd1:    b = f.xs;
                4'd2:    b = f.ys;
                4'd3:    b = f.xe;
                4'd4:    b = f.ye;
                4'd5:    b = f.colour;
                default: begin
                    if (idx == TAIL_X) begin
                        b = f.xs;
                    end else if (idx == TAIL_Y) begin
                        b = f.ys;
                    end else begin
                        b = PAD_BYTE;
                    end
                end
            endcase
        end
        return b;
    endfunction

    state_t     state_r;
    frame_t     cur_r;
    logic [3:0] idx_r;
    logic [7:0] gap_cnt_r;
    logic [7:0] cmd_r;
    logic       busy_r;
    logic       done_r;
    logic       ready_r;

    logic       accept_s;
    frame_t     incoming_s;
    logic       last_byte_s;
    logic       gap_end_s;
    logic       enter_gap_s;
    logic       release_s;
    logic       start_s;
    frame_t     start_req_s;
    state_t     next_state_s;
    logic       ready_next_s;

`ifdef GFX_CMD_QUEUE_EN
    logic       q_valid_r;
    frame_t     q_req_r;
    logic       q_load_s;
    logic       q_clear_s;
    logic       q_valid_next_s;
`endif

    // Frame sequencing decisions: accept, end of frame/gap, what starts next.
    always_comb begin
        accept_s    = req_valid && ready_r;
        incoming_s  = normalise(req_line, req_x0, req_y0, req_x1, req_y1, req_colour);
        last_byte_s = (state_r == SEND) &&
                      (idx_r == (cur_r.line ? LINE_LAST : POINT_LAST));
        gap_end_s   = (state_r == GAP) && (gap_cnt_r == GAP_LAST);
        enter_gap_s = last_byte_s && cur_r.line && HAS_GAP;
        // release: the running frame (or its gap) ends on this edge
        release_s   = (last_byte_s && !enter_gap_s) || gap_end_s;
        start_s     = 1'b0;
        start_req_s = incoming_s;
`ifdef GFX_CMD_QUEUE_EN
        q_load_s    = 1'b0;
        q_clear_s   = 1'b0;
        if (state_r == IDLE) begin
            // idle with an empty queue: bypass straight into the frame
            start_s = accept_s;
        end else if (release_s && q_valid_r) begin
            start_s     = 1'b1;
            start_req_s = q_req_r;
            q_clear_s   = 1'b1;
        end else if (release_s) begin
            // request arriving on the very edge the predecessor ends
            start_s = accept_s;
        end else begin
            q_load_s = accept_s;
        end
        if (q_load_s) begin
            q_valid_next_s = 1'b1;
        end else if (q_clear_s) begin
            q_valid_next_s = 1'b0;
        end else begin
            q_valid_next_s = q_valid_r;
        end
`else
        if (state_r == IDLE) begin
            start_s = accept_s;
        end else begin
            start_s = 1'b0;
        end
`endif
        if (start_s) begin
            next_state_s = SEND;
        end else if (enter_gap_s) begin
            next_state_s = GAP;
        end else if (release_s) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = state_r;
        end
`ifdef GFX_CMD_QUEUE_EN
        ready_next_s = !q_valid_next_s;
`else
        ready_next_s = (next_state_s == IDLE);
`endif
    end

    // Issuer FSM with registered cmd/busy/frame_done/req_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cur_r     <= '0;
            idx_r     <= 4'd0;
            gap_cnt_r <= 8'd0;
            cmd_r     <= PAD_BYTE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ready_r   <= 1'b0;
`ifdef GFX_CMD_QUEUE_EN
            q_valid_r <= 1'b0;
            q_req_r   <= '0;
`endif
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            done_r  <= last_byte_s;
            ready_r <= ready_next_s;
            if (start_s) begin
                cur_r <= start_req_s;
                idx_r <= 4'd0;
                cmd_r <= frame_byte(start_req_s, 4'd0);
            end else if ((state_r == SEND) && !last_byte_s) begin
                idx_r <= idx_r + 4'd1;
                cmd_r <= frame_byte(cur_r, idx_r + 4'd1);
            end else begin
                cmd_r <= PAD_BYTE;
            end
            if (enter_gap_s) begin
                gap_cnt_r <= 8'd0;
            end else if (state_r == GAP) begin
                gap_cnt_r <= gap_cnt_r + 8'd1;
            end else begin
                gap_cnt_r <= gap_cnt_r;
            end
`ifdef GFX_CMD_QUEUE_EN
            q_valid_r <= q_valid_next_s;
            if (q_load_s) begin
                q_req_r <= incoming_s;
            end else begin
                q_req_r <= q_req_r;
            end
`endif
        end
    end

    assign cmd        = cmd_r;
    assign busy       = busy_r;
    assign frame_done = done_r;
    assign req_ready  = ready_r;

endmodule

// File: tb/tb_gfx_cmd_issuer.sv
// Self-checking bench for gfx_cmd_issuer (default parameters).
// A slot-based reference model schedules every accepted frame into per-cycle
// expectation arrays; directed table vectors, corner sequences and random
// traffic are all compared against it and against hand-written byte tables.
module tb_gfx_cmd_issuer;

    localparam logic [7:0] PAD  = 8'd0;
    localparam int         SP   = 5;
    localparam int         GC   = 4;
    localparam int         MAXC = 4096;
`ifdef GFX_CMD_QUEUE_EN
    localparam bit QUEUED = 1'b1;
`else
    localparam bit QUEUED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_line;
    logic [7:0] req_x0, req_y0, req_x1, req_y1, req_colour;
    logic [7:0] cmd;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    gfx_cmd_issuer dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_line   (req_line),
        .req_x0     (req_x0),
        .req_y0     (req_y0),
        .req_x1     (req_x1),
        .req_y1     (req_y1),
        .req_colour (req_colour),
        .cmd        (cmd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: expected outputs per cycle, plus bookkeeping times.
    logic [7:0] m_cmd  [MAXC];
    bit         m_busy [MAXC];
    bit         m_done [MAXC];
    int         free_c   = 0;   // first cycle the issuer is idle again
    int         qlim     = 0;   // queue occupied up to (excluding) this cycle
    int         rst_last = -1;  // cycle in which reset was last applied
    bit         last_acc = 1'b0;

    typedef struct {
        bit         line;
        logic [7:0] x0, y0, x1, y1, c;
        int         len;
        logic [127:0] exp;   // byte i at [127-8i -: 8]
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready(input int t);
        if (t == rst_last) return 1'b0;
        if (QUEUED) return (t >= qlim);
        return (t >= free_c);
    endfunction

    // Lays out one frame starting with its opcode in cycle s.
    task automatic model_start(input int s, input bit line, input logic [7:0] a0,
                               input logic [7:0] b0, input logic [7:0] a1,
                               input logic [7:0] b1, input logic [7:0] c);
        logic [7:0] xs, ys, xe, ye;
        int n, g;
        if (line && (a1 < a0)) begin
            xs = a1; ys = b1; xe = a0; ye = b0;
        end else begin
            xs = a0; ys = b0; xe = a1; ye = b1;
        end
        if (line) begin
            n = 8 + SP;
            g = GC;
            m_cmd[s]   = 8'd76;
            m_cmd[s+1] = xs;
            m_cmd[s+2] = ys;
            m_cmd[s+3] = xe;
            m_cmd[s+4] = ye;
            m_cmd[s+5] = c;
            for (int i = 0; i < SP; i++) m_cmd[s+6+i] = PAD;
            m_cmd[s+6+SP] = xs;
            m_cmd[s+7+SP] = ys;
        end else begin
            n = 4;
            g = 0;
            m_cmd[s]   = 8'd80;
            m_cmd[s+1] = a0;
            m_cmd[s+2] = b0;
            m_cmd[s+3] = c;
        end
        for (int i = 0; i < n + g; i++) m_busy[s+i] = 1'b1;
        m_done[s+n] = 1'b1;
        free_c = s + n + g;
    endtask

    // Drives one cycle of inputs, advances the model, checks the next cycle.
    task automatic step(input bit r, input bit v, input bit line, input logic [7:0] a0,
                        input logic [7:0] b0, input logic [7:0] a1,
                        input logic [7:0] b1, input logic [7:0] c);
        int s;
        rst = r; req_valid = v; req_line = line;
        req_x0 = a0; req_y0 = b0; req_x1 = a1; req_y1 = b1; req_colour = c;
        last_acc = 1'b0;
        if (r) begin
            for (int i = cyc + 1; i < cyc + 64 && i < MAXC; i++) begin
                m_cmd[i] = PAD; m_busy[i] = 1'b0; m_done[i] = 1'b0;
            end
            rst_last = cyc + 1;
            free_c   = cyc + 1;
            qlim     = cyc + 1;
        end else if (v && m_ready(cyc)) begin
            s = (free_c > cyc + 1) ? free_c : cyc + 1;
            if (s > cyc + 1) qlim = s;
            model_start(s, line, a0, b0, a1, b1, c);
            last_acc = 1'b1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("cmd", {24'd0, cmd}, {24'd0, m_cmd[cyc]});
        chk("busy", {31'd0, busy}, {31'd0, m_busy[cyc]});
        chk("frame_done", {31'd0, frame_done}, {31'd0, m_done[cyc]});
        chk("req_ready", {31'd0, req_ready}, {31'd0, m_ready(cyc)});
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_ready(cyc) && cyc >= free_c) && n < 60) begin
            idle_step();
            n++;
        end
        chk("wait_idle_bound", {31'd0, (n < 60)}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int opc;
        int p_cycle;
        bit held_acc;
        logic [127:0] e;
        bit r, v, ln;
        logic [7:0] a0, b0, a1, b1, c;

        for (int i = 0; i < MAXC; i++) begin
            m_cmd[i] = PAD; m_busy[i] = 1'b0; m_done[i] = 1'b0;
        end
        tbl[0] = '{1'b0, 8'd5, 8'd7, 8'd0, 8'd0, 8'h3C, 4,
                   {8'd80, 8'd5, 8'd7, 8'h3C, 96'd0}};
        tbl[1] = '{1'b1, 8'd2, 8'd1, 8'd10, 8'd4, 8'hFF, 13,
                   {8'd76, 8'd2, 8'd1, 8'd10, 8'd4, 8'hFF, 40'd0, 8'd2, 8'd1, 24'd0}};
        tbl[2] = '{1'b1, 8'd10, 8'd4, 8'd2, 8'd1, 8'hFF, 13,
                   {8'd76, 8'd2, 8'd1, 8'd10, 8'd4, 8'hFF, 40'd0, 8'd2, 8'd1, 24'd0}};
        tbl[3] = '{1'b1, 8'd9, 8'd1, 8'd9, 8'd200, 8'h11, 13,
                   {8'd76, 8'd9, 8'd1, 8'd9, 8'd200, 8'h11, 40'd0, 8'd9, 8'd1, 24'd0}};
        tbl[4] = '{1'b0, 8'd255, 8'd0, 8'd1, 8'd1, 8'hAA, 4,
                   {8'd80, 8'd255, 8'd0, 8'hAA, 96'd0}};
        tbl[5] = '{1'b1, 8'd255, 8'd3, 8'd0, 8'd8, 8'h5A, 13,
                   {8'd76, 8'd0, 8'd8, 8'd255, 8'd3, 8'h5A, 40'd0, 8'd0, 8'd8, 24'd0}};

        // Reset, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("reset_cmd", {24'd0, cmd}, {24'd0, PAD});
        chk("reset_ready", {31'd0, req_ready}, 32'd0);
        idle_step();
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Directed vectors against hand-written byte tables.
        for (int k = 0; k < 6; k++) begin
            wait_idle();
            step(1'b0, 1'b1, tbl[k].line, tbl[k].x0, tbl[k].y0, tbl[k].x1, tbl[k].y1, tbl[k].c);
            e = tbl[k].exp;
            for (int i = 0; i < tbl[k].len; i++) begin
                chk($sformatf("tbl%0d_byte%0d", k, i), {24'd0, cmd}, {24'd0, e[127-8*i -: 8]});
                idle_step();
            end
            chk($sformatf("tbl%0d_done", k), {31'd0, frame_done}, 32'd1);
        end

        // Reset on the third byte of a line frame.
        wait_idle();
        step(1'b0, 1'b1, 1'b1, 8'd2, 8'd1, 8'd10, 8'd4, 8'hFF);
        idle_step();
        idle_step();
        chk("rst_mid_third_byte", {24'd0, cmd}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("rst_mid_cmd", {24'd0, cmd}, {24'd0, PAD});
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, frame_done}, 32'd0);
        for (int i = 0; i < 16; i++) idle_step();
        wait_idle();
        step(1'b0, 1'b1, 1'b0, 8'd33, 8'd44, 8'd0, 8'd0, 8'h77);
        chk("post_rst_point_op", {24'd0, cmd}, 32'd80);

        // Reset wins over a simultaneous accept.
        wait_idle();
        step(1'b1, 1'b1, 1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        idle_step();
        chk("rst_prio_cmd", {24'd0, cmd}, {24'd0, PAD});
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);

        // Request held valid while a line frame runs.
        wait_idle();
        step(1'b0, 1'b1, 1'b1, 8'd2, 8'd1, 8'd10, 8'd4, 8'hFF);
        opc = cyc;
        p_cycle = -1;
        held_acc = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, !held_acc, 1'b0, 8'd9, 8'd8, 8'd0, 8'd0, 8'h42);
            if (last_acc) held_acc = 1'b1;
            if (p_cycle < 0 && cmd == 8'd80) p_cycle = cyc;
        end
        chk("held_p_offset", p_cycle - opc, QUEUED ? 32'd17 : 32'd18);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 2) != 0);
            ln = $urandom_range(0, 1) != 0;
            a0 = 8'($urandom);
            b0 = 8'($urandom);
            a1 = ($urandom_range(0, 5) == 0) ? a0 : 8'($urandom);
            b1 = 8'($urandom);
            c  = 8'($urandom);
            step(r, v, ln, a0, b0, a1, b1, c);
        end
        for (int i = 0; i < 40; i++) idle_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
